// File: rtl/countdown_timer.sv
// Two-digit BCD countdown with a built-in one-second prescaler.
// Presets come from the mode selector; 00 selects the 60 s mode.
module countdown_timer #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] init_val0,
  input  logic [3:0] init_val1,
  input  logic       load,
  input  logic       start_stop,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_digit0;
  logic [3:0]       r_digit1;
  logic [3:0]       w_digit0_next;
  logic [3:0]       w_digit1_next;
  logic [CNT_W-1:0] r_presc;
  logic [CNT_W-1:0] w_presc_next;
  logic             r_running;
  logic             r_done;

  logic [3:0]       w_map0;
  logic [3:0]       w_map1;
  logic             w_tick;
  logic             w_last_sec;

  // Preset mapping: 00 means a full minute, otherwise clamp each digit to 9.
  always_comb begin
    w_map1 = (init_val1 > 4'd9) ? 4'd9 : init_val1;
    w_map0 = (init_val0 > 4'd9) ? 4'd9 : init_val0;
    if ((init_val1 == 4'd0) && (init_val0 == 4'd0)) begin
      w_map1 = 4'd6;
      w_map0 = 4'd0;
    end
  end

  assign w_tick     = (r_presc == TICK_LAST);
  assign w_last_sec = (r_digit1 == 4'd0) && (r_digit0 <= 4'd1);

  always_comb begin
    w_state_next  = r_state;
    w_digit0_next = r_digit0;
    w_digit1_next = r_digit1;
    w_presc_next  = r_presc;

    if (load) begin
      w_state_next  = S_IDLE;
      w_digit0_next = w_map0;
      w_digit1_next = w_map1;
      w_presc_next  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_digit0_next = w_map0;
          w_digit1_next = w_map1;
          w_presc_next  = '0;
          if (start_stop) begin
            w_state_next = S_COUNT;
          end
        end

        S_COUNT: begin
          if (start_stop) begin
            // A decrement due this cycle is dropped; the prescaler keeps its phase.
            w_state_next = S_PAUSE;
          end else if (w_tick) begin
            w_presc_next = '0;
            if (w_last_sec) begin
              w_digit0_next = 4'd0;
              w_digit1_next = 4'd0;
              w_state_next  = S_DONE;
            end else if (r_digit0 != 4'd0) begin
              w_digit0_next = r_digit0 - 4'd1;
            end else begin
              w_digit0_next = 4'd9;
              w_digit1_next = r_digit1 - 4'd1;
            end
          end else begin
            w_presc_next = r_presc + CNT_W'(1);
          end
        end

        S_PAUSE: begin
          if (start_stop) begin
            w_state_next = S_COUNT;
          end
        end

        S_DONE: begin
          w_digit0_next = 4'd0;
          w_digit1_next = 4'd0;
          w_presc_next  = '0;
          if (start_stop) begin
            w_state_next  = S_IDLE;
            w_digit0_next = w_map0;
            w_digit1_next = w_map1;
          end
        end

        default: begin
          w_state_next = S_IDLE;
          w_presc_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_digit0  <= 4'd0;
      r_digit1  <= 4'd0;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_digit0  <= w_digit0_next;
      r_digit1  <= w_digit1_next;
      r_presc   <= w_presc_next;
      r_running <= (w_state_next == S_COUNT);
      r_done    <= (w_state_next == S_DONE);
    end
  end

  assign digit0  = r_digit0;
  assign digit1  = r_digit1;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD two-digit countdown stage that sits directly downstream of the 30 s/60 s mode selector.
- Consumes the selector's preset digits (init_val1 = tens, init_val0 = ones) and runs an internal 1 Hz prescaler.
- Counts down under start/pause control and drives the seven-segment display digits plus a done indicator.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second decrement (1 Hz at 100 MHz); must be >= 2.
- CNT_W, 27, width of prescaler counter; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- init_val0  input  4  preset ones digit (BCD) from mode selector
- init_val1  input  4  preset tens digit (BCD) from mode selector
- load  input  1  one-cycle pulse: abort and reload preset
- start_stop  input  1  one-cycle pulse (already debounced/one-pulsed): start/pause toggle
- digit0  output  4  current ones digit (BCD)
- digit1  output  4  current tens digit (BCD)
- running  output  1  high while in COUNT
- done  output  1  high while in DONE

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, digit1=0, digit0=0, prescaler=0, running=0, done=0. Overrides all other inputs.
- Preset mapping, applied in IDLE and on load:
  - init 0,0 means 60 s: load digit1=6, digit0=0.
  - Any preset digit >9 is clamped to 9.
  - Otherwise digits are copied directly.
- States: IDLE, COUNT, PAUSE, DONE. running=(state==COUNT); done=(state==DONE); both registered.
- IDLE:
  - Digits track the mapped preset every cycle, so a mode change is visible 1 cycle later.
  - Prescaler held at 0.
  - start_stop -> COUNT.
- COUNT:
  - Prescaler increments each cycle. When it reaches TICK_DIV-1 it wraps to 0 and issues a decrement in that same edge.
  - First decrement occurs exactly TICK_DIV cycles after entering COUNT from IDLE.
  - Decrement rule:
    - If digit0!=0: digit0-1.
    - Else: digit0=9, digit1-1.
  - If the pre-decrement value is 01, result 00 and next state=DONE.
  - start_stop -> PAUSE; a decrement due in the same cycle is discarded and the prescaler holds its value.
- PAUSE:
  - Digits and prescaler frozen.
  - start_stop -> COUNT; prescaler resumes from its held value, so no partial second is lost or repeated.
- DONE:
  - Digits hold 00; prescaler 0.
  - start_stop -> IDLE; digits take the mapped preset on the next edge.
- load, any state except reset: next state=IDLE, digits=mapped preset, prescaler=0. load has priority over start_stop and over a decrement in the same cycle.
- Digits never go below 00 and never leave the BCD range 0-9.
- No combinational path from any input to any output.

Test Plan:
- TICK_DIV=4, preset 3,0, pulse start_stop: running=1 next cycle; digits 30->29 after 4 cycles, 29->28 after 8 cycles; digit0 wraps 0->9 with digit1 decremented.
- Preset 0,0 in IDLE -> digits read 6,0 within 1 cycle; start, run 60*TICK_DIV cycles -> digits 00, done=1, running=0; further cycles keep 00.
- TICK_DIV=4, start, pause after 2 cycles, idle 10 cycles, resume -> next decrement 2 cycles after resume; digits frozen throughout PAUSE.
- start_stop and decrement in the same COUNT cycle -> state PAUSE, digits unchanged; load and start_stop together in COUNT -> IDLE with preset reloaded, running=0.
- DONE with preset 3,0, pulse start_stop -> IDLE, digits 30; preset 11,5 (>9) -> digits 95.
- Drive rst=0 mid-COUNT at digits 17 -> next edge digits 00, running=0, done=0, IDLE; next cycle after release digits = mapped preset.
